// File: rtl/imm_instruction_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of the RV32I immediate encoder.
// master drives fields and out_ready; slave is the encoder.
interface imm_instruction_encoder_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            in_opcode;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [2:0]            in_funct3;
    logic [6:0]            in_funct7;
    logic [31:0]           in_imm;

    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_inst;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_err;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output out_ready,
        input  in_ready,
        input  out_valid, out_inst, out_addr, out_err
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  out_ready,
        output in_ready,
        output out_valid, out_inst, out_addr, out_err
    );
endinterface

// File: rtl/imm_instruction_encoder.sv
// Packs register/funct/immediate fields into RV32I words and streams them out as an
// addressed burst, flagging immediates that are out of range or misaligned for their format.
module imm_instruction_encoder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ADDR_STEP  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  count,
    imm_instruction_encoder_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err_sticky
);

    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [CNT_WIDTH-1:0]  remaining;

    logic                  accept;
    logic                  valid_nxt;
    logic [CNT_WIDTH-1:0]  remaining_nxt;

    logic [31:0]           imm;
    logic                  fits_12;
    logic                  fits_13;
    logic                  fits_21;
    logic [31:0]           enc_inst;
    logic                  enc_ok;

    assign bus.in_ready  = (state == RUN) && (remaining != '0) && (!bus.out_valid || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign valid_nxt     = accept || (bus.out_valid && !bus.out_ready);
    assign remaining_nxt = remaining - CNT_WIDTH'(accept);

    // A signed immediate fits N bits when everything above bit N-2 is pure sign extension.
    assign imm     = bus.in_imm;
    assign fits_12 = (&imm[31:11]) || !(|imm[31:11]);
    assign fits_13 = (&imm[31:12]) || !(|imm[31:12]);
    assign fits_21 = (&imm[31:20]) || !(|imm[31:20]);

    // Format selection and packing; rejected words become a NOP.
    always_comb begin
        enc_inst = NOP_INST;
        enc_ok   = 1'b0;
        case (bus.in_opcode)
            OP_IMM, OP_LOAD, OP_JALR: begin
                enc_ok   = fits_12;
                enc_inst = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            end
            OP_STORE: begin
                enc_ok   = fits_12;
                enc_inst = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0],
                            bus.in_opcode};
            end
            OP_BRANCH: begin
                enc_ok   = fits_13 && !imm[0];
                enc_inst = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            imm[4:1], imm[11], bus.in_opcode};
            end
            OP_JAL: begin
                enc_ok   = fits_21 && !imm[0];
                enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
            end
            OP_REG: begin
                enc_ok   = 1'b1;
                enc_inst = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd,
                            bus.in_opcode};
            end
            default: begin
                enc_ok   = 1'b0;
                enc_inst = NOP_INST;
            end
        endcase
        if (!enc_ok) begin
            enc_inst = NOP_INST;
        end
    end

    // Burst control and output register; the burst ends once the last word has drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            addr_cnt      <= '0;
            remaining     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_sticky    <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_inst  <= '0;
            bus.out_addr  <= '0;
            bus.out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        addr_cnt   <= base_addr;
                        remaining  <= count;
                        err_sticky <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        bus.out_valid <= 1'b1;
                        bus.out_inst  <= enc_inst;
                        bus.out_addr  <= addr_cnt;
                        bus.out_err   <= !enc_ok;
                        if (!enc_ok) begin
                            err_sticky <= 1'b1;
                        end
                        addr_cnt  <= addr_cnt + ADDR_WIDTH'(ADDR_STEP);
                        remaining <= remaining_nxt;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                    end
                    if ((remaining_nxt == '0) && !valid_nxt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imm_instruction_encoder.md
Name: imm_instruction_encoder

Overview:
- Reverse direction of the immediate decode path: packs register, funct and immediate fields into 32-bit RV32I instruction words.
- Writes an ordered stream of encoded words, each tagged with an incrementing instruction-memory address.
- Used by the boot/instruction-memory loader and by benches for round-trip checks against the immediate generator.
- Performs immediate range and alignment checks per format, and runs a start/count burst state machine with valid/ready on both sides.

Parameters:
- ADDR_WIDTH, 32, width of the output address and address counter.
- ADDR_STEP, 4, byte increment between consecutive words.
- CNT_WIDTH, 16, width of the burst word count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; reset when 0.
- start  in  1  one-cycle burst start; honoured only in IDLE or DONE.
- base_addr  in  ADDR_WIDTH  address of the first word, sampled on start.
- count  in  CNT_WIDTH  number of words in the burst, sampled on start.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- in_opcode  in  7  RV32I opcode.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field; used only for R-type.
- in_imm  in  32  signed byte-offset immediate.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts the word.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_WIDTH  address of out_inst.
- out_err  out  1  this word failed its range or alignment check.
- busy  out  1  state is RUN.
- done  out  1  state is DONE (level).
- err_sticky  out  1  any out_err in the current burst.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (reset=0, takes effect immediately):
  - state=IDLE; every output register and counter is 0.
  - out_valid, busy, done and err_sticky are 0.
  - Any word in flight is dropped.
- start in IDLE or DONE:
  - Load addr_cnt=base_addr and remaining=count, clear err_sticky, go to RUN.
  - start in RUN is ignored.
- in_ready = (state==RUN) && (remaining!=0) && (!out_valid || out_ready).
- Accept when in_valid && in_ready. On the next edge:
  - out_valid=1, out_inst=encode(fields), out_addr=addr_cnt, out_err=check failure.
  - addr_cnt += ADDR_STEP, wrapping modulo 2^ADDR_WIDTH.
  - remaining -= 1.
  - Input-to-output latency is 1 cycle.
- Output handshake:
  - While out_valid && !out_ready, out_inst, out_addr and out_err hold stable.
  - If out_ready=1 and there is no new accept, out_valid clears on the next edge.
  - Accept and drain in the same cycle give back-to-back words, 1 word/cycle sustained.
- RUN->DONE on the edge where remaining==0 and out_valid will be 0, i.e. the last word has been consumed.
  - A burst started with count==0 reaches DONE on the edge after start and emits no words.
- Encoding by opcode (imm = in_imm):
  - I-type, opcodes 0010011, 0000011, 1100111: {imm[11:0], rs1, funct3, rd, opcode}. Valid iff imm is in [-2048, 2047].
  - S-type, opcode 0100011: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}. Same range as I-type.
  - B-type, opcode 1100011: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}. Valid iff imm is in [-4096, 4094] and imm[0]==0.
  - J-type, opcode 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}. Valid iff imm is in [-2^20, 2^20-2] and imm[0]==0.
  - R-type, opcode 0110011: {funct7, rs2, rs1, funct3, rd, opcode}. in_imm is ignored; always valid.
  - Any other opcode is invalid.
- Invalid word:
  - out_inst=32'h00000013 (NOP), out_err=1, err_sticky=1.
  - The word still consumes an address and a count slot.
- Round-trip property: for every valid I/S/B/J word, the immediate generator applied to out_inst returns in_imm exactly.

Test Plan:
1. start, base_addr=0x100, count=3; send ADDI x1,x0,-1, then SW x2,8(x1), then BEQ x0,x0,-4.
   -> out_inst 0xFFF00093 @0x100, 0x0020A423 @0x104, 0xFE000EE3 @0x108.
   -> out_err=0 on all three; done=1 after the third word is consumed.
2. JAL x1,+2048 -> out_inst=0x001000EF.
   JAL imm=-2 -> 0xFFFFF0EF (rd=x1).
   Feed both through the immediate generator -> 2048 and -2.
3. ADDI imm=2048 -> 0x00000013, out_err=1, err_sticky=1.
   BRANCH imm=3 -> out_err=1.
   Opcode 0110111 -> out_err=1.
   A new start clears err_sticky.
4. out_ready held 0 for 5 cycles with in_valid=1 -> out_inst and out_addr stable, in_ready=0, remaining unchanged.
   Release -> next word is emitted on the following edge with addr +4.
5. count=0 -> done=1 on the edge after start, out_valid never 1.
   start pulsed mid-RUN -> ignored, addresses continue.
   base_addr=0xFFFFFFFC, count=2 -> second out_addr=0x00000000.
6. reset driven to 0 after 1 of 3 words -> out_valid=0, busy=0, done=0 immediately without a clock edge.
   After release, state=IDLE and in_ready=0 until start.
